// File: rtl/agc_pkg.sv
// Shared types and helpers for the automatic level controller: gain codes,
// FSM states, ladder index <-> gain code conversion and sample magnitude.
package agc_pkg;

    localparam int SAMPLE_W = 24;
    localparam logic [SAMPLE_W-1:0] MAG_SAT    = 24'h7FFFFF;
    localparam logic [SAMPLE_W-1:0] MAG_NEG_FS = 24'h800000;

    localparam logic [2:0] IDX_MIN   = 3'd0;
    localparam logic [2:0] IDX_MAX   = 3'd4;
    localparam logic [2:0] IDX_RESET = 3'd2;

    typedef enum logic [2:0] {
        G0DB  = 3'd0,
        G6DB  = 3'd1,
        G12DB = 3'd2,
        L12DB = 3'd3,
        L6DB  = 3'd4
    } gain_code_e;

    typedef enum logic {
        ST_MEASURE = 1'b0,
        ST_DECIDE  = 1'b1
    } agc_state_e;

    // Ladder runs from -12 dB at index 0 to +12 dB at index 4.
    function automatic gain_code_e indexToCode(input logic [2:0] idx);
        case (idx)
            3'd0:    return L12DB;
            3'd1:    return L6DB;
            3'd2:    return G0DB;
            3'd3:    return G6DB;
            3'd4:    return G12DB;
            default: return G0DB;
        endcase
    endfunction

    // Codes 5-7 are not on the ladder and fall back to the 0 dB position.
    function automatic logic [2:0] codeToIndex(input logic [2:0] code);
        case (code)
            3'd3:    return 3'd0;
            3'd4:    return 3'd1;
            3'd0:    return 3'd2;
            3'd1:    return 3'd3;
            3'd2:    return 3'd4;
            default: return IDX_RESET;
        endcase
    endfunction

    // The most negative sample has no positive twin, so it saturates.
    function automatic logic [SAMPLE_W-1:0] magnitude(input logic [SAMPLE_W-1:0] x);
        if (!x[SAMPLE_W-1]) return x;
        if (x == MAG_NEG_FS) return MAG_SAT;
        return -x;
    endfunction

endpackage

// File: rtl/agc_level_ctrl_peak_detector.sv
// Window peak detector: running max of sample magnitude, sample counter and
// window-end strobe; with AGC_FAST_CLIP_EN it also flags clipping samples.
module peak_detector
    import agc_pkg::*;
#(
    parameter int WINDOW_LEN = 4800
`ifdef AGC_FAST_CLIP_EN
    , parameter logic [SAMPLE_W-1:0] CLIP_THR = 24'h7F0000
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [SAMPLE_W-1:0] data_i,
`ifdef AGC_FAST_CLIP_EN
    input  logic                clipArm_i,
    output logic                clip_o,
`endif
    output logic                winEnd_o,
    output logic [SAMPLE_W-1:0] winPeak_o
);

    localparam int CNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_LEN - 1);

    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic [CNT_W-1:0]    sampleCnt_q, sampleCnt_d;
    logic [SAMPLE_W-1:0] mag, runPeak;
    logic                lastSample, clipHit;

    always_comb begin
        mag        = magnitude(data_i);
        runPeak    = (mag > peak_q) ? mag : peak_q;
        lastSample = valid_i && (sampleCnt_q == CNT_LAST);
`ifdef AGC_FAST_CLIP_EN
        clipHit    = valid_i && clipArm_i && (mag >= CLIP_THR);
`else
        clipHit    = 1'b0;
`endif
        peak_d      = peak_q;
        sampleCnt_d = sampleCnt_q;
        // A clip restarts the window exactly like a completed window does.
        if (clipHit || lastSample) begin
            peak_d      = '0;
            sampleCnt_d = '0;
        end else if (valid_i) begin
            peak_d      = runPeak;
            sampleCnt_d = sampleCnt_q + CNT_W'(1);
        end
        winEnd_o  = lastSample && !clipHit;
        winPeak_o = runPeak;
`ifdef AGC_FAST_CLIP_EN
        clip_o    = clipHit;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            peak_q      <= '0;
            sampleCnt_q <= '0;
        end else begin
            peak_q      <= peak_d;
            sampleCnt_q <= sampleCnt_d;
        end
    end

endmodule

// File: rtl/agc_level_ctrl.sv
// Automatic level controller producing the gain-stage select code.
// Optional fast clip reduction is enabled by defining AGC_FAST_CLIP_EN.
module agc_level_ctrl
    import agc_pkg::*;
#(
    parameter int          WINDOW_LEN = 4800,
    parameter logic [23:0] LOW_THR    = 24'h100000,
    parameter logic [23:0] HIGH_THR   = 24'h600000,
    parameter int          HOLD_WIN   = 4,
    parameter logic [23:0] CLIP_THR   = 24'h7F0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        agc_en_i,
    input  logic [2:0]  manual_choose_i,
    input  logic        aud_valid_i,
    input  logic [23:0] data_i,
    output logic [2:0]  choose_o,
    output logic        change_o,
    output logic [23:0] peak_o
);

    localparam int HOLD_W = (HOLD_WIN > 0) ? $clog2(HOLD_WIN + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_WIN);

    agc_state_e         state_q, state_d;
    logic [2:0]         index_q, index_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [2:0]         choose_q, choose_d;
    logic               change_q, change_d;
    logic [23:0]        peak_q, peak_d;
    logic               winEnd, clipHit;
    logic [23:0]        winPeak;

    peak_detector #(
        .WINDOW_LEN(WINDOW_LEN)
`ifdef AGC_FAST_CLIP_EN
        , .CLIP_THR(CLIP_THR)
`endif
    ) u_peak (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (aud_valid_i),
        .data_i    (data_i),
`ifdef AGC_FAST_CLIP_EN
        .clipArm_i (agc_en_i && (index_q != IDX_MIN)),
        .clip_o    (clipHit),
`endif
        .winEnd_o  (winEnd),
        .winPeak_o (winPeak)
    );

`ifndef AGC_FAST_CLIP_EN
    assign clipHit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        hold_d   = hold_q;
        change_d = 1'b0;
        peak_d   = peak_q;

        if (winEnd) peak_d = winPeak;

        case (state_q)
            ST_MEASURE: if (winEnd) state_d = ST_DECIDE;
            ST_DECIDE:  state_d = winEnd ? ST_DECIDE : ST_MEASURE;
            default:    state_d = ST_MEASURE;
        endcase

        // Manual mode keeps the index tracking the operator's code so AGC resumes from it.
        if (!agc_en_i) begin
            index_d = codeToIndex(manual_choose_i);
            hold_d  = '0;
        end else if (clipHit) begin
            index_d  = index_q - 3'd1;
            hold_d   = HOLD_RELOAD;
            change_d = 1'b1;
            state_d  = ST_MEASURE;
        end else if (state_q == ST_DECIDE) begin
            if (peak_q >= HIGH_THR && index_q > IDX_MIN) begin
                index_d  = index_q - 3'd1;
                hold_d   = HOLD_RELOAD;
                change_d = 1'b1;
            end else if (peak_q < LOW_THR && index_q < IDX_MAX && hold_q == '0) begin
                index_d  = index_q + 3'd1;
                hold_d   = HOLD_RELOAD;
                change_d = 1'b1;
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end

        choose_d = agc_en_i ? indexToCode(index_d) : manual_choose_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_MEASURE;
            index_q  <= IDX_RESET;
            hold_q   <= '0;
            choose_q <= G0DB;
            change_q <= 1'b0;
            peak_q   <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            hold_q   <= hold_d;
            choose_q <= choose_d;
            change_q <= change_d;
            peak_q   <= peak_d;
        end
    end

    assign choose_o = choose_q;
    assign change_o = change_q;
    assign peak_o   = peak_q;

endmodule

// File: tb/tb_agc_level_ctrl.sv
// Self-checking bench for agc_level_ctrl: directed windows from the test plan
// followed by randomized windows, all checked against a ladder/hold model.
module tb_agc_level_ctrl;

    localparam int WIN    = 64;
    localparam int HOLD   = 4;
    localparam int LOW_T  = 'h100000;
    localparam int HIGH_T = 'h600000;

    logic        clk = 1'b0;
    logic        rst, agcEn, audValid, changeO;
    logic [2:0]  manualChoose, chooseO;
    logic [23:0] data, peakO;

    int testsRun    = 0;
    int testsFailed = 0;
    int pulseCnt    = 0;
    int mIdx        = 2;
    int mHold       = 0;
    int ladderCode [5] = '{3, 4, 0, 1, 2};
    logic [23:0] winQ[$];

    always #5 clk = ~clk;

    agc_level_ctrl #(
        .WINDOW_LEN(WIN),
        .LOW_THR   (24'h100000),
        .HIGH_THR  (24'h600000),
        .HOLD_WIN  (HOLD),
        .CLIP_THR  (24'h7F0000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .agc_en_i       (agcEn),
        .manual_choose_i(manualChoose),
        .aud_valid_i    (audValid),
        .data_i         (data),
        .choose_o       (chooseO),
        .change_o       (changeO),
        .peak_o         (peakO)
    );

    // Counts every cycle in which change_o is seen high.
    always @(posedge clk) begin
        #1;
        if (changeO === 1'b1) pulseCnt++;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int magOf(input logic [23:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 'h7FFFFF) v = 'h7FFFFF;
        return v;
    endfunction

    function automatic int manualIndex(input int code);
        int idx;
        idx = 2;
        for (int i = 0; i < 5; i++) if (ladderCode[i] == code) idx = i;
        return idx;
    endfunction

    function automatic int expectedChoose();
        return agcEn ? ladderCode[mIdx] : int'(manualChoose);
    endfunction

    task automatic doReset(input string tag);
        rst = 1'b1;
        audValid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mIdx = 2;
        mHold = 0;
        @(negedge clk);
        checkOutput({tag, "/choose"}, chooseO, 0);
        checkOutput({tag, "/change"}, changeO, 0);
        checkOutput({tag, "/peak"},   peakO,   0);
    endtask

    task automatic setMode(input logic en, input logic [2:0] code);
        int pulses0;
        pulses0 = pulseCnt;
        agcEn = en;
        manualChoose = code;
        if (!en) begin
            mIdx = manualIndex(int'(code));
            mHold = 0;
        end
        @(negedge clk);
        checkOutput("mode/choose", chooseO, expectedChoose());
        checkOutput("mode/pulses", pulseCnt - pulses0, 0);
    endtask

    function automatic void fillConst(input logic [23:0] v);
        winQ.delete();
        repeat (WIN) winQ.push_back(v);
    endfunction

    function automatic void fillSpike(input logic [23:0] base, input logic [23:0] spike, input int pos);
        fillConst(base);
        winQ[pos] = spike;
    endfunction

    // cls 0: quiet, 1: mid-level spike, 2: loud spike, 3: threshold boundary spike.
    function automatic void fillRandom(input int cls);
        int v;
        int pick;
        logic [23:0] spike;
        winQ.delete();
        repeat (WIN) begin
            v = int'($urandom_range('h0FFFFF, 0));
            winQ.push_back(($urandom_range(1, 0) == 1) ? 24'(-v) : 24'(v));
        end
        case (cls)
            1: v = int'($urandom_range(HIGH_T - 1, LOW_T));
            2: v = int'($urandom_range('h800000, HIGH_T));
            3: begin
                pick = int'($urandom_range(3, 0));
                v = (pick == 0) ? LOW_T : (pick == 1) ? LOW_T - 1 :
                    (pick == 2) ? HIGH_T : HIGH_T - 1;
            end
            default: v = int'($urandom_range('h0FFFFF, 0));
        endcase
        if (v == 'h800000) spike = 24'h800000;
        else spike = ($urandom_range(1, 0) == 1) ? 24'(-v) : 24'(v);
        winQ[$urandom_range(WIN - 1, 0)] = spike;
    endfunction

    // Plays winQ as one window with random idle gaps, then checks the decision timing.
    task automatic applyStimulus(input int maxGap, input string tag);
        int peak;
        int expChange;
        int pulses0;
        int chooseBefore;
        peak = 0;
        expChange = 0;
        pulses0 = pulseCnt;
        chooseBefore = expectedChoose();
        foreach (winQ[i]) begin
            repeat ($urandom_range(maxGap, 0)) begin
                audValid = 1'b0;
                @(negedge clk);
            end
            audValid = 1'b1;
            data = winQ[i];
            if (magOf(winQ[i]) > peak) peak = magOf(winQ[i]);
            @(negedge clk);
        end
        audValid = 1'b0;
        checkOutput({tag, "/peak"},   peakO,   peak);
        checkOutput({tag, "/early"},  chooseO, chooseBefore);
        if (agcEn) begin
            if (peak >= HIGH_T && mIdx > 0) begin
                mIdx--;
                mHold = HOLD;
                expChange = 1;
            end else if (peak < LOW_T && mIdx < 4 && mHold == 0) begin
                mIdx++;
                mHold = HOLD;
                expChange = 1;
            end else if (mHold > 0) begin
                mHold--;
            end
        end
        @(negedge clk);
        checkOutput({tag, "/choose"}, chooseO, expectedChoose());
        checkOutput({tag, "/change"}, changeO, expChange);
        @(negedge clk);
        checkOutput({tag, "/pulses"}, pulseCnt - pulses0, expChange);
    endtask

    initial begin
        rst = 1'b1;
        agcEn = 1'b1;
        manualChoose = 3'd0;
        audValid = 1'b0;
        data = '0;
        doReset("reset");

        // Quiet window steps up, then hold-off blocks the next up-step for 4 windows.
        fillConst(24'h050000);
        applyStimulus(0, "quietUp");
        for (int w = 0; w < 5; w++) applyStimulus(1, "holdoff");

        // Single loud sample at +12 dB steps down, then hold-off again.
        fillSpike(24'h020000, 24'h700000, 17);
        applyStimulus(1, "spikeDown");
        fillConst(24'h020000);
        for (int w = 0; w < 5; w++) applyStimulus(0, "spikeHold");

        // Negative full scale saturates the magnitude.
        fillSpike(24'h010000, 24'h800000, 40);
        applyStimulus(0, "negFs");

        // Exact thresholds: HIGH_THR steps down, LOW_THR does not step up.
        fillConst(24'h600000);
        applyStimulus(0, "atHigh");
        for (int w = 0; w < 5; w++) begin
            fillConst(24'h100000);
            applyStimulus(0, "atLow");
        end

        // Ladder bottom: loud windows saturate at -12 dB with no pulse.
        fillConst(24'h7FFFFF);
        for (int w = 0; w < 4; w++) applyStimulus(0, "bottom");

        // Manual pass-through, measurement continues, then resume from resynced index.
        setMode(1'b0, 3'd6);
        fillSpike(24'h000000, 24'h650000, 5);
        applyStimulus(1, "manualWin");
        setMode(1'b1, 3'd6);
        fillConst(24'h680000);
        applyStimulus(0, "resumeLoud");
        setMode(1'b0, 3'd1);
        setMode(1'b1, 3'd1);

        // Reset partway through a window discards the partial window.
        for (int i = 0; i < 30; i++) begin
            audValid = 1'b1;
            data = 24'h700000;
            @(negedge clk);
        end
        doReset("midReset");
        fillConst(24'h700000);
        applyStimulus(0, "freshWin");

        // Randomized windows with occasional manual excursions.
        for (int w = 0; w < 30; w++) begin
            if ($urandom_range(5, 0) == 0) setMode(1'b0, 3'($urandom_range(7, 0)));
            else if (!agcEn) setMode(1'b1, manualChoose);
            fillRandom(int'($urandom_range(3, 0)));
            applyStimulus(int'($urandom_range(2, 0)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/agc_level_ctrl.md
# agc_level_ctrl

Automatic level controller that produces the 3-bit gain select code consumed by the audio gain stage. It measures the peak magnitude of the incoming 24-bit signed audio over fixed sample windows and steps the gain up or down the 6 dB ladder with hold-off hysteresis. It sits in parallel with the gain stage on the same sample stream and drives that stage's `choose` input.

## Interface
- `WINDOW_LEN`, default 4800: valid samples per measurement window (100 ms at 48 kHz).
- `LOW_THR`, default 24'h100000: step up when window peak < LOW_THR. Must be < HIGH_THR/2.
- `HIGH_THR`, default 24'h600000: step down when window peak >= HIGH_THR.
- `HOLD_WIN`, default 4: windows to wait after any change before an up-step is allowed.
- `CLIP_THR`, default 24'h7F0000: fast-clip threshold (used only with the macro).
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `agc_en_i`  in  1  1 = automatic; 0 = manual pass-through.
- `manual_choose_i`  in  3  gain code used while `agc_en_i`=0.
- `aud_valid_i`  in  1  one-cycle strobe qualifying `data_i`.
- `data_i`  in  24  signed audio sample (pre-gain).
- `choose_o`  out  3  registered gain code: 0=0 dB, 1=+6, 2=+12, 3=−12, 4=−6.
- `change_o`  out  1  one-cycle pulse when `choose_o` changes under AGC.
- `peak_o`  out  24  last completed window peak (unsigned magnitude).

## Operation
- Ladder index 0..4 maps to codes 3,4,0,1,2 (−12…+12 dB). `choose_o` is always the code for the current index while AGC is enabled.
- Magnitude: |x| for x ≥ 0; −x for x < 0; −2^23 saturates to 24'h7FFFFF.
- Per valid sample: `peak` := max(peak, |x|), and `sample_cnt` increments.
- On the valid sample where `sample_cnt`=WINDOW_LEN−1: the final peak (including this sample) is latched into `peak_o`; `peak` and `sample_cnt` clear; the FSM enters DECIDE.
- FSM states:
  - MEASURE: accumulates samples.
  - DECIDE: one cycle, then returns to MEASURE.
    - If peak ≥ HIGH_THR and index > 0: index−1, reload hold := HOLD_WIN, pulse.
    - Else if peak < LOW_THR, index < 4 and hold = 0: index+1, reload hold, pulse.
    - Else: if hold > 0, hold−1.
  - Samples arriving during DECIDE count toward the new window.
- Saturation at the ends of the ladder: no step, no pulse, and hold still decrements.
- `agc_en_i`=0:
  - `choose_o` <= `manual_choose_i` every cycle; `change_o`=0.
  - The window keeps measuring and `peak_o` keeps updating.
  - Index resyncs to the manual code. Codes 5–7 map to index 2.
  - Hold clears.
- `agc_en_i` rising: AGC resumes from the resynced index. The current window continues.
- Reset values:
  - `choose_o`=0, index=2.
  - `change_o`=0, `peak_o`=0.
  - peak=0, sample_cnt=0, hold=0.
  - State MEASURE.
- Reset mid-window discards the partial window.

## Timing
- Final window sample accepted at edge N.
- DECIDE is active in the cycle after N.
- `choose_o`/`change_o` update at the following edge: 2 cycles after the final sample's strobe.
- `peak_o` updates 1 cycle after the final sample.
- `change_o` is high for exactly 1 cycle.
- `manual_choose_i` → `choose_o` latency: 1 cycle.
- `aud_valid_i` may be asserted every cycle. There is no back-pressure.

## Configuration
- `AGC_FAST_CLIP_EN` defined:
  - Any valid sample with |x| ≥ CLIP_THR while AGC is enabled and index > 0 forces index−1 and hold := HOLD_WIN.
  - It pulses `change_o` one cycle later.
  - It restarts the window: peak and sample_cnt clear, and `peak_o` is not updated.
  - If this coincides with a window's final sample, the clip wins and DECIDE is skipped.
- Undefined: reductions occur only in DECIDE, and CLIP_THR is unused.

## Structure
- `agc_pkg` contains:
  - The gain code enum: G0DB=0, G6DB=1, G12DB=2, L12DB=3, L6DB=4.
  - The index↔code conversion functions.
  - The FSM state enum.
- Sub-module `peak_detector` holds the abs/saturation, running max, sample counter and window-end strobe. It also produces the clip strobe when the macro is defined.
- The top level holds the FSM, ladder index, hold counter and output registers.

## Test plan
- Reset, then 4800 samples of 24'h050000: `peak_o`=24'h050000, `choose_o` 0→1 with one `change_o` pulse. Next up-step only after 4 further windows (HOLD_WIN).
- From index 4 (+12), one window containing a single sample of 24'h700000: `choose_o` 2→1. Subsequent quiet windows give no up-step for 4 windows.
- Negative full scale 24'h800000 in a window: `peak_o`=24'h7FFFFF and a step down.
- `agc_en_i`=0 with `manual_choose_i`=6: `choose_o`=6 after 1 cycle, no pulse. Re-enable, then a loud window: index 2→1, `choose_o`=4.
- With `AGC_FAST_CLIP_EN`: a sample of 24'h7F8000 at sample 100 gives `choose_o` 0→4 one cycle later, `peak_o` unchanged, and the window restarts (next DECIDE 4800 samples later).
- Assert `rst_i` at sample 2000 of a window: all outputs return to reset values. The next DECIDE occurs after 4800 fresh samples.
